// File: rtl/riscv_axi_rd_arb_pkg.sv
// Shared constants and helpers for the 2:1 AXI read-channel arbiter.
package riscv_axi_rd_arb_pkg;

    // Source index carried in the slave-side ARID/RID MSB.
    localparam logic AXI_SRC_EXU = 1'b0;  // port 0, data side
    localparam logic AXI_SRC_IFU = 1'b1;  // port 1, instruction fetch

    // Width of the outstanding-burst counter (OUTSTANDING is at most 15).
    localparam int CNT_W = 4;

    // Round-robin pick between two requesters: a lone requester wins.
    // On a tie, the port that did not win last time wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] pick;
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/riscv_axi_rd_arb_rr_arb2.sv
// Two-way round-robin arbiter; owns the last-grant history bit.
module riscv_rr_arb2
    import riscv_axi_rd_arb_pkg::*;
(
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_grant;

    // One-hot grant, suppressed entirely when the consumer cannot take a request.
    always_comb begin
        gnt = 2'b00;
        if (en) gnt = rr_pick(req, last_grant);
    end

    // Remember the winner; reset favours port 0 on the first tie.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)  last_grant <= AXI_SRC_IFU;
        else if (|gnt) last_grant <= gnt[1];
    end

endmodule

// File: rtl/riscv_axi_rd_arb.sv
// 2:1 AXI4 read arbiter: registered round-robin AR, outstanding-burst limit,
// zero-latency R demux keyed on the RID MSB.
module riscv_axi_rd_arb
    import riscv_axi_rd_arb_pkg::*;
#(
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [1:0]             M_ARVALID,
    output logic [1:0]             M_ARREADY,
    input  logic [1:0][ID_W-1:0]   M_ARID,
    input  logic [1:0][ADDR_W-1:0] M_ARADDR,
    input  logic [1:0][7:0]        M_ARLEN,
    input  logic [1:0][2:0]        M_ARSIZE,
    input  logic [1:0][1:0]        M_ARBURST,
    output logic [1:0]             M_RVALID,
    input  logic [1:0]             M_RREADY,
    output logic [ID_W-1:0]        M_RID,
    output logic [DATA_W-1:0]      M_RDATA,
    output logic [1:0]             M_RRESP,
    output logic                   M_RLAST,
    output logic                   S_ARVALID,
    input  logic                   S_ARREADY,
    output logic [ID_W:0]          S_ARID,
    output logic [ADDR_W-1:0]      S_ARADDR,
    output logic [7:0]             S_ARLEN,
    output logic [2:0]             S_ARSIZE,
    output logic [1:0]             S_ARBURST,
    input  logic                   S_RVALID,
    output logic                   S_RREADY,
    input  logic [ID_W:0]          S_RID,
    input  logic [DATA_W-1:0]      S_RDATA,
    input  logic [1:0]             S_RRESP,
    input  logic                   S_RLAST
);

    logic [CNT_W-1:0] outst_cnt;
    logic             can_take;
    logic [1:0]       gnt;
    logic             sel;
    logic             r_src;
    logic             r_last_hs;
    logic             cnt_inc;
    logic             cnt_dec;

    // The slot can accept when empty or draining this cycle, and the burst budget allows.
    // Held off during reset so no grant leaks out while the block is being cleared.
    always_comb begin
        can_take = (!S_ARVALID || S_ARREADY) && (outst_cnt < CNT_W'(OUTSTANDING)) && ARESETn;
        sel      = gnt[1];
    end

    riscv_rr_arb2 u_arb (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .req     (M_ARVALID),
        .en      (can_take),
        .gnt     (gnt)
    );

    assign M_ARREADY = gnt;

    // AR slot: load on grant (also covers back-to-back drain+reload), clear on drain.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            S_ARVALID <= 1'b0;
            S_ARID    <= '0;
            S_ARADDR  <= '0;
            S_ARLEN   <= '0;
            S_ARSIZE  <= '0;
            S_ARBURST <= '0;
        end else if (|gnt) begin
            S_ARVALID <= 1'b1;
            S_ARID    <= {sel, M_ARID[sel]};
            S_ARADDR  <= M_ARADDR[sel];
            S_ARLEN   <= M_ARLEN[sel];
            S_ARSIZE  <= M_ARSIZE[sel];
            S_ARBURST <= M_ARBURST[sel];
        end else if (S_ARREADY) begin
            S_ARVALID <= 1'b0;
        end
    end

    // R demux: route each beat by the source bit in RID; no buffering.
    always_comb begin
        r_src     = S_RID[ID_W];
        M_RVALID  = r_src ? {S_RVALID, 1'b0} : {1'b0, S_RVALID};
        S_RREADY  = M_RREADY[r_src];
        M_RID     = S_RID[ID_W-1:0];
        M_RDATA   = S_RDATA;
        M_RRESP   = S_RRESP;
        M_RLAST   = S_RLAST;
        r_last_hs = S_RVALID && S_RREADY && S_RLAST;
        cnt_inc   = |gnt;
        cnt_dec   = r_last_hs && (outst_cnt != '0);
    end

    // Bursts in flight: counted from grant until the final R beat is accepted.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) outst_cnt <= '0;
        else if (cnt_inc && !cnt_dec) outst_cnt <= outst_cnt + 1'b1;
        else if (!cnt_inc && cnt_dec) outst_cnt <= outst_cnt - 1'b1;
    end

    // A closing beat with nothing in flight means the slave returned a burst nobody asked for.
    a_no_orphan_rlast : assert property (@(posedge ACLK) disable iff (!ARESETn)
        !(r_last_hs && outst_cnt == '0));

endmodule
